// File: rtl/accel_bus_master.sv
// accel_bus_master: expands high-level accelerator commands into single-packet bus transactions
// Ports: clk/rst (sync, active-low); cmd_* command handshake; done pulse, sticky error;
//        mem_* packet-wide scratch port (read data one cycle after mem_rd_en);
//        bus_master_* request/finish slave bus with packet in/out.
module accel_bus_master #(
  parameter int          PACKET_WIDTH            = 256,
  parameter int          ARRAY_SIZE              = 16,
  parameter int          INTRA_ROW_BIT           = 5,
  parameter int          MEM_ADDR_WIDTH          = 10,
  parameter int          TIMEOUT_CYCLES          = 1024,
  parameter logic [31:0] INPUT_FIFO_BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] WEIGHT_FIFO_BASE_ADDR   = 32'h0001_0000,
  parameter logic [31:0] OUTPUT_BUFFER_BASE_ADDR = 32'h0002_0000,
  parameter logic [31:0] MOVE_ADDR               = 32'h0003_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_src,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_dst,
  output logic                      done,
  output logic                      error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [PACKET_WIDTH-1:0]   mem_rd_data,
  output logic                      mem_wr_en,
  output logic [PACKET_WIDTH-1:0]   mem_wr_data,
  output logic [31:0]               bus_master_addr,
  output logic                      bus_master_read_request,
  output logic                      bus_master_write_request,
  output logic [PACKET_WIDTH-1:0]   bus_master_output,
  input  logic [PACKET_WIDTH-1:0]   bus_master_input,
  input  logic                      bus_master_request_finish
);
  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP, WBACK, DONE, ERR} state_t;
  // phases are numbered in TILE order so TILE simply walks them upward
  typedef enum logic [2:0] {P_RIN, P_RWT, P_ROUT, P_LIN, P_LWT, P_MM, P_SV, P_MV} phase_t;
  state_t state_q, state_d;
  phase_t ph_q, ph_d, sph, nph;
  logic [2:0] op_q, op_d;
  logic [MEM_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, lbase, mrow;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PACKET_WIDTH-1:0] out_q, out_d, cap_q, cap_d;
  logic err_q, err_d, fresh_q, fresh_d;
  logic is_load, is_save, is_rst, multi, last_row, last_ph;
  logic [31:0] rbase, row_off;
  function automatic logic ld(input phase_t p);
    return p == P_LIN || p == P_LWT;
  endfunction
  always_comb begin
    is_load  = ld(ph_q);
    is_save  = ph_q == P_SV;
    is_rst   = ph_q <= P_ROUT;
    multi    = is_load || is_save;
    last_row = row_q == RW'(ARRAY_SIZE - 1);
    last_ph  = op_q == 3'd6 ? ph_q == P_SV : op_q == 3'd0 ? ph_q == P_ROUT : 1'b1;
    nph      = phase_t'(ph_q + 3'd1);
    sph      = (cmd_op == 3'd0 || cmd_op == 3'd6) ? P_RIN : cmd_op == 3'd5 ? P_MV : phase_t'(cmd_op + 3'd2);
    row_off  = 32'(row_q) << INTRA_ROW_BIT;
    rbase    = (ph_q == P_RIN || ph_q == P_LIN) ? INPUT_FIFO_BASE_ADDR :
               (ph_q == P_RWT || ph_q == P_LWT) ? WEIGHT_FIFO_BASE_ADDR :
               ph_q == P_MV ? MOVE_ADDR : OUTPUT_BUFFER_BASE_ADDR;
    // TILE keeps weight rows directly after the input rows
    lbase    = is_save ? dst_q : (ph_q == P_LWT && op_q == 3'd6) ? src_q + MEM_ADDR_WIDTH'(ARRAY_SIZE) : src_q;
    mrow     = lbase + MEM_ADDR_WIDTH'(row_q);
  end
  assign cmd_ready                = state_q == IDLE;
  assign done                     = state_q == DONE;
  assign error                    = err_q;
  assign mem_rd_en                = state_q == FETCH;
  assign mem_wr_en                = state_q == GAP && is_save;
  assign mem_addr                 = (mem_rd_en || mem_wr_en) ? mrow : '0;
  assign mem_wr_data              = cap_q;
  assign bus_master_read_request  = state_q == ISSUE && (is_save || is_rst || ph_q == P_MV);
  assign bus_master_write_request = state_q == ISSUE && !is_save;
  assign bus_master_addr          = state_q == ISSUE ? rbase + (multi ? row_off : 32'd0) : 32'd0;
  // scratch data arrives in the first ISSUE cycle; pass it through then, hold the copy after
  assign bus_master_output        = fresh_q ? mem_rd_data : out_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ph_d    = ph_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cap_d   = cap_q;
    err_d   = err_q;
    fresh_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        src_d   = cmd_src;
        dst_d   = cmd_dst;
        err_d   = cmd_op == 3'd7;
        ph_d    = sph;
        row_d   = '0;
        cnt_d   = '0;
        state_d = cmd_op == 3'd7 ? ERR : ld(sph) ? FETCH : ISSUE;
      end
      FETCH: begin
        fresh_d = 1'b1;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (fresh_q) out_d = mem_rd_data;
        if (bus_master_request_finish) begin
          if (is_save) cap_d = bus_master_input;
          state_d = GAP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: begin
        cnt_d = '0;
        if (multi && !last_row) begin
          row_d   = row_q + 1'b1;
          state_d = is_load ? FETCH : ISSUE;
        end else if (last_ph) state_d = DONE;
        else begin
          ph_d    = nph;
          row_d   = '0;
          state_d = ld(nph) ? FETCH : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      ph_q    <= P_RIN;
      row_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      fresh_q <= fresh_d;
    end
  end
endmodule

// File: tb/tb_accel_bus_master.sv
// tb_accel_bus_master: randomized command stimulus checked against a transaction-list reference model
module tb_accel_bus_master;
  localparam int PW = 256, AS = 16, IRB = 5, MW = 10, TO = 64;
  localparam logic [31:0] IB = 32'h4000_0000, WB = 32'h4000_1000, OB = 32'h4000_2000, MV = 32'h4000_3000;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_op = 0;
  logic [MW-1:0] cmd_src = 0, cmd_dst = 0, mem_addr;
  logic done, error, mem_rd_en, mem_wr_en;
  logic [PW-1:0] mem_rd_data = 0, mem_wr_data, bout, bin = 0;
  logic [31:0] baddr;
  logic rq, wq, fin = 0, inited = 0;
  typedef struct {logic rd; logic wr; logic [31:0] addr; logic ld; logic [PW-1:0] data;} txn_t;
  txn_t exp_q[$];
  logic [MW-1:0] wa_q[$];
  logic [PW-1:0] wd_q[$];
  logic [PW-1:0] mem [0:1023];
  int nvec = 0, nerr = 0, lat = 0, wcnt = 0, hi_cnt = 0, last_len = 0, done_cnt = 0, fin_cnt = 0;
  always #5 clk = ~clk;
  accel_bus_master #(.PACKET_WIDTH(PW), .ARRAY_SIZE(AS), .INTRA_ROW_BIT(IRB), .MEM_ADDR_WIDTH(MW),
    .TIMEOUT_CYCLES(TO), .INPUT_FIFO_BASE_ADDR(IB), .WEIGHT_FIFO_BASE_ADDR(WB),
    .OUTPUT_BUFFER_BASE_ADDR(OB), .MOVE_ADDR(MV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .done(done), .error(error), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .bus_master_addr(baddr), .bus_master_read_request(rq), .bus_master_write_request(wq),
    .bus_master_output(bout), .bus_master_input(bin), .bus_master_request_finish(fin));
  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (!rst && !inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {8{32'(i)}};
      inited <= 1;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end
  // slave + monitor: finish after lat extra cycles, one-cycle finish pulse
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      fin = 0;
      wcnt = 0;
    end else begin
      if (done) done_cnt++;
      if (rq | wq) hi_cnt++;
      else if (hi_cnt > 0) begin
        last_len = hi_cnt;
        hi_cnt = 0;
      end
      if (mem_wr_en) begin
        if (wa_q.size() == 0 || wd_q.size() == 0) chk("spurious_wr", 1, 0);
        else begin
          chk("wr_addr", PW'(mem_addr), PW'(wa_q.pop_front()));
          chk("wr_data", mem_wr_data, wd_q.pop_front());
        end
      end
      if (fin) begin
        chk("gap", PW'(rq | wq), 0);
        fin = 0;
        wcnt = 0;
      end else if (rq | wq) begin
        if (exp_q.size() == 0) chk("spurious_req", PW'(rq | wq), 0);
        else begin
          t = exp_q[0];
          chk("rd_req", PW'(rq), PW'(t.rd));
          chk("wr_req", PW'(wq), PW'(t.wr));
          chk("addr", PW'(baddr), PW'(t.addr));
          if (t.ld) chk("wdata", bout, t.data);
          if (wcnt >= lat) begin
            fin = 1;
            fin_cnt++;
            for (int k = 0; k < 8; k++) bin[k*32 +: 32] = $urandom;
            if (t.rd && !t.wr) wd_q.push_back(bin);
            void'(exp_q.pop_front());
          end else wcnt++;
        end
      end
    end
  end
  function automatic void push_t(input logic rd, input logic wr, input logic [31:0] a, input logic ld, input logic [PW-1:0] d);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.ld = ld; t.data = d;
    exp_q.push_back(t);
  endfunction
  task automatic model(input int op, input logic [MW-1:0] s, input logic [MW-1:0] d);
    logic [MW-1:0] a;
    if (op == 0 || op == 6) begin
      push_t(1, 1, IB, 0, 0);
      push_t(1, 1, WB, 0, 0);
      push_t(1, 1, OB, 0, 0);
    end
    if (op == 1 || op == 6)
      for (int r = 0; r < AS; r++) begin
        a = s + MW'(r);
        push_t(0, 1, IB + 32'(r << IRB), 1, mem[a]);
      end
    if (op == 2 || op == 6)
      for (int r = 0; r < AS; r++) begin
        a = s + MW'(r) + (op == 6 ? MW'(AS) : MW'(0));
        push_t(0, 1, WB + 32'(r << IRB), 1, mem[a]);
      end
    if (op == 3 || op == 6) push_t(0, 1, OB, 0, 0);
    if (op == 4 || op == 6)
      for (int r = 0; r < AS; r++) begin
        push_t(1, 0, OB + 32'(r << IRB), 0, 0);
        wa_q.push_back(d + MW'(r));
      end
    if (op == 5) push_t(1, 1, MV, 0, 0);
  endtask
  task automatic issue(input int op, input logic [MW-1:0] s, input logic [MW-1:0] d, input int l, input string tag);
    lat = l;
    done_cnt = 0;
    model(op, s, d);
    @(negedge clk);
    chk({tag, "_ready"}, PW'(cmd_ready), 1);
    cmd_valid = 1; cmd_op = 3'(op); cmd_src = s; cmd_dst = d;
    @(negedge clk);
    cmd_valid = 0;
    chk({tag, "_busy"}, PW'(cmd_ready), 0);
    chk({tag, "_errclr"}, PW'(error), PW'(op == 7));
  endtask
  task automatic run(input int op, input logic [MW-1:0] s, input logic [MW-1:0] d, input int l,
                     input int edone, input int eerr, input string tag);
    int n;
    issue(op, s, d, l, tag);
    n = 0;
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_term"}, PW'(n < 20000), 1);
    chk({tag, "_done"}, PW'(done_cnt), PW'(edone));
    chk({tag, "_err"}, PW'(error), PW'(eerr));
    if (eerr == 0) begin
      chk({tag, "_txleft"}, PW'(exp_q.size()), 0);
      chk({tag, "_wrleft"}, PW'(wa_q.size()), 0);
    end
    exp_q.delete(); wa_q.delete(); wd_q.delete();
  endtask
  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    chk("rst_req", PW'({rq, wq}), 0);
    chk("rst_addr", PW'(baddr), 0);
    chk("rst_out", bout, 0);
    chk("rst_mem", PW'({mem_rd_en, mem_wr_en, mem_addr}), 0);
    chk("rst_flags", PW'({done, error}), 0);
    rst = 1;
    @(negedge clk);
    chk("rst_ready", PW'(cmd_ready), 1);
    run(1, 10'h010, 0, 0, 1, 0, "load_in");
    run(3, 0, 0, 46, 1, 0, "matmul");
    chk("matmul_len", PW'(last_len), 47);
    run(4, 0, 10'h3F8, 1, 1, 0, "save_wrap");
    for (int i = 0; i < AS; i++) chk("save_mem", mem[10'h3F8 + MW'(i)], mem[10'h3F8 + MW'(i)] === 'x ? 1 : mem[10'h3F8 + MW'(i)]);
    run(3, 0, 0, 1000000, 0, 1, "timeout");
    chk("timeout_len", PW'(last_len), TO);
    run(5, 0, 0, 2, 1, 0, "move");
    run(7, 0, 0, 0, 0, 1, "op7");
    run(2, 10'h3FA, 0, 1, 1, 0, "load_wt");
    run(6, 10'h100, 10'h200, 0, 1, 0, "tile");
    base = fin_cnt;
    issue(1, 10'h040, 0, 2, "rst_mid");
    n = 0;
    while (!(fin_cnt == base + 5 && (rq | wq) && !fin) && n < 2000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("rst_mid_reach", PW'(n < 2000), 1);
    rst = 0;
    @(negedge clk);
    #1 chk("rst_mid_req", PW'({rq, wq}), 0);
    chk("rst_mid_ready", PW'(cmd_ready), 1);
    chk("rst_mid_flags", PW'({done_cnt != 0, error}), 0);
    rst = 1;
    exp_q.delete(); wa_q.delete(); wd_q.delete();
    run(0, 0, 0, 1, 1, 0, "reset_cmd");
    for (int i = 0; i < 10; i++)
      run($urandom_range(0, 6), MW'($urandom), MW'($urandom), $urandom_range(0, 3), 1, 0, "rand");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/accel_bus_master.md
Name: accel_bus_master

Overview:
- CPU-side initiator that drives the accelerator bus-slave protocol: address, read/write request pair and packet data, holding each request until the accelerator returns request-finish.
- Accepts one high-level command at a time: reset, load input/weight rows, matmul, save result rows, move, or a full tile sequence.
- Expands each command into a sequence of single-packet bus transactions.
- Moves packets between a local packet-wide scratch memory and the accelerator.
- A per-transaction watchdog flags a hung slave.

Parameters:
- PACKET_WIDTH, 256, bus packet width in bits (one array row).
- ARRAY_SIZE, 16, rows transferred per load/save command.
- INTRA_ROW_BIT, 5, address shift per row; row r of a region is at base + (r << INTRA_ROW_BIT).
- MEM_ADDR_WIDTH, 10, local scratch row-address width.
- TIMEOUT_CYCLES, 1024, maximum cycles a request may wait for finish.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle; command accepted when valid&ready
- cmd_op  in  3  0 RESET, 1 LOAD_IN, 2 LOAD_WT, 3 MATMUL, 4 SAVE, 5 MOVE, 6 TILE, 7 reserved
- cmd_src  in  MEM_ADDR_WIDTH  first scratch row for LOAD_IN (TILE: input rows; weight rows at cmd_src+ARRAY_SIZE)
- cmd_dst  in  MEM_ADDR_WIDTH  first scratch row for SAVE/TILE results
- done  out  1  one-cycle pulse when a command completes
- error  out  1  sticky until next accepted command; set on watchdog expiry or op 7
- mem_addr  out  MEM_ADDR_WIDTH  scratch row address
- mem_rd_en  out  1  scratch read; data valid next cycle
- mem_rd_data  in  PACKET_WIDTH  scratch read data
- mem_wr_en  out  1  scratch write
- mem_wr_data  out  PACKET_WIDTH  scratch write data
- bus_master_addr  out  32  transaction address
- bus_master_read_request  out  1  read request
- bus_master_write_request  out  1  write request
- bus_master_output  out  PACKET_WIDTH  write packet
- bus_master_input  in  PACKET_WIDTH  read packet (valid while finish high)
- bus_master_request_finish  in  1  slave finish

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all request, mem and done outputs 0; error 0; addr/data outputs 0; cmd_ready 1 on the following cycle.
- Transaction encoding:
  - load: write=1, read=0, addr = INPUT_FIFO_BASE_ADDR or WEIGHT_FIFO_BASE_ADDR + row offset.
  - save: read=1, write=0, addr = OUTPUT_BUFFER_BASE_ADDR + row offset.
  - matmul: write=1, read=0, addr = OUTPUT_BUFFER_BASE_ADDR.
  - reset: both requests 1, addr = the region base.
  - move: both requests 1, addr = MOVE_ADDR.
- Command sequences:
  - RESET: three resets in order (input FIFO, weight FIFO, output buffer).
  - LOAD_IN / LOAD_WT: ARRAY_SIZE loads, rows 0..ARRAY_SIZE-1.
  - MATMUL: one matmul.
  - SAVE: ARRAY_SIZE saves.
  - MOVE: one move.
  - TILE: RESET, LOAD_IN, LOAD_WT, MATMUL, SAVE, in that order.
- States: IDLE, FETCH, ISSUE, GAP, WBACK, DONE, ERR.
- IDLE: on accept, latch op/src/dst; go to FETCH for load steps, otherwise ISSUE.
- FETCH: one cycle with mem_rd_en=1 and mem_addr = row address. Next edge registers mem_rd_data into bus_master_output; go to ISSUE.
- ISSUE:
  - Request lines, addr and output are held constant until bus_master_request_finish is sampled 1.
  - On that edge: save steps capture bus_master_input, then go to GAP.
  - Finish seen in the first ISSUE cycle is legal; minimum ISSUE length is 1 cycle.
- GAP:
  - Both requests 0 for exactly one cycle; mandatory between transactions so the slave clears its finish flags.
  - Save steps assert mem_wr_en with mem_addr = dst+row and mem_wr_data = captured packet during GAP.
  - Then advance to the next step (FETCH/ISSUE) or DONE.
- DONE: done=1 for one cycle, then IDLE.
- Watchdog:
  - Counter clears on ISSUE entry.
  - If it reaches TIMEOUT_CYCLES without finish: drop requests, set error, go to ERR, then IDLE with no done pulse. Remaining steps are abandoned.
- Op 7: error set, no bus activity, return to IDLE, no done.
- cmd_ready=1 only in IDLE; cmd_valid is ignored elsewhere.
- Row counter 0..ARRAY_SIZE-1; mem address = base + row and wraps modulo 2^MEM_ADDR_WIDTH.
- Reset mid-command: requests drop at that edge and the command is lost; no done, no error.

Test Plan:
- LOAD_IN with src=0x010 and scratch rows holding row index; slave finishes 1 cycle after request -> 16 write transactions at INPUT_FIFO_BASE_ADDR+0x00..+0x1E0, data = rows 0x010..0x01F, one idle cycle between each, one done pulse.
- MATMUL with slave finishing after 47 cycles -> write request at OUTPUT_BUFFER_BASE_ADDR held 47 cycles, low the cycle after finish, done next.
- SAVE with dst=0x3F8 -> 16 reads; slave data written to scratch 0x3F8..0x3FF then 0x000..0x007 (wrap), one write per GAP.
- Slave never finishes, TIMEOUT_CYCLES=8 -> request high exactly 8 cycles then 0, error=1, no done; next accepted command clears error.
- TILE -> exact sequence 3 resets, 16+16 loads, 1 matmul, 16 saves (52 transactions), single done at end.
- rst=0 during load row 5 -> requests 0 after edge, cmd_ready 1, no done; a fresh RESET then completes normally.
